// File: rtl/cnt_reload_pkg.sv
// Shared types and constants for the reloadable counter-chain sequencer.
// Holds the FSM state encoding, the per-state control decode and event-counter sizing.
package cnt_reload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  typedef struct packed {
    logic sp;
    logic sd;
    logic ci;
    logic busy;
  } ctrl_t;

  localparam int MIN_PERIOD = 2;

  localparam int                ECNT_W   = 8;
  localparam logic [ECNT_W-1:0] ECNT_MAX = 8'd255;

  // Fixed chain-control pattern for each state; every output is a pure function of state.
  function automatic ctrl_t state_ctrl(input state_t st);
    ctrl_t c;
    c = '{sp: 1'b0, sd: 1'b0, ci: 1'b0, busy: 1'b0};
    case (st)
      ST_LOAD: c = '{sp: 1'b1, sd: 1'b1, ci: 1'b0, busy: 1'b1};
      ST_RUN:  c = '{sp: 1'b1, sd: 1'b0, ci: 1'b1, busy: 1'b1};
      ST_HOLD: c = '{sp: 1'b0, sd: 1'b0, ci: 1'b0, busy: 1'b1};
      default: c = '{sp: 1'b0, sd: 1'b0, ci: 1'b0, busy: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cnt_reload_shadow.sv
// One-entry shadow register for the requested period with a valid/ready write port.
// A write always wins over a same-edge transfer, so the new value stays pending.
module cnt_reload_shadow
  import cnt_reload_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             ldv,
  input  logic [WIDTH-1:0] ldd,
  input  logic             xfer,
  output logic             ldr,
  output logic             pending,
  output logic [WIDTH-1:0] shadow
);

  logic             pending_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic             wr;

  assign wr = ldv & ~pending_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      pending_reg <= 1'b0;
      shadow_reg  <= '0;
    end else if (wr) begin
      shadow_reg  <= ldd;
      pending_reg <= 1'b1;
    end else if (xfer) begin
      pending_reg <= 1'b0;
    end
  end

  assign ldr     = ~pending_reg;
  assign pending = pending_reg;
  assign shadow  = shadow_reg;

endmodule

// File: rtl/cnt_reload_seq.sv
// Sequencer for a cascaded 4-bit loadable up-counter chain: loads 1-Pe, counts to
// terminal count, then reloads (AUTO=1) or stops (AUTO=0), emitting an event per period.
module cnt_reload_seq
  import cnt_reload_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit AUTO  = 1'b1
) (
  input  logic              CK,
  input  logic              CD,
  input  logic              LDV,
  input  logic [WIDTH-1:0]  LDD,
  output logic              LDR,
  input  logic              GO,
  input  logic              HALT,
  input  logic              STOP,
  input  logic              TC,
  output logic              SP,
  output logic              SD,
  output logic              CI,
  output logic [WIDTH-1:0]  D,
  output logic              EVT,
  output logic              BUSY,
  output logic [ECNT_W-1:0] ECNT
);

  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
      $error("cnt_reload_seq: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t            state_reg;
  state_t            state_next;
  ctrl_t             ctrl_reg;
  logic [WIDTH-1:0]  period_reg;
  logic [WIDTH-1:0]  d_reg;
  logic [WIDTH-1:0]  period_sel;
  logic [WIDTH-1:0]  period_eff;
  logic              evt_reg;
  logic              evt_next;
  logic              enter_load;
  logic              restart;
  logic [ECNT_W-1:0] ecnt_reg;
  logic              pending;
  logic [WIDTH-1:0]  shadow;

  cnt_reload_shadow #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .clk    (CK),
    .srst   (CD),
    .ldv    (LDV),
    .ldd    (LDD),
    .xfer   (enter_load),
    .ldr    (LDR),
    .pending(pending),
    .shadow (shadow)
  );

  // TC outranks HALT in RUN; STOP outranks everything.
  always_comb begin
    state_next = state_reg;
    if (STOP) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (GO) state_next = ST_LOAD;
        ST_LOAD: state_next = ST_RUN;
        ST_RUN: begin
          if (TC)        state_next = AUTO ? ST_LOAD : ST_IDLE;
          else if (HALT) state_next = ST_HOLD;
        end
        ST_HOLD: if (!HALT) state_next = ST_RUN;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    period_sel = pending ? shadow : period_reg;
    period_eff = (period_sel < MIN_P) ? MIN_P : period_sel;
  end

  assign enter_load = (state_next == ST_LOAD) && (state_reg != ST_LOAD);
  assign restart    = (state_reg == ST_IDLE) && (state_next == ST_LOAD);
  assign evt_next   = (state_reg == ST_RUN) && TC && !STOP;

  always_ff @(posedge CK) begin
    if (CD) begin
      state_reg  <= ST_IDLE;
      ctrl_reg   <= state_ctrl(ST_IDLE);
      period_reg <= MIN_P;
      d_reg      <= ONE - MIN_P;
      evt_reg    <= 1'b0;
      ecnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= state_ctrl(state_next);
      evt_reg   <= evt_next;
      if (enter_load) begin
        period_reg <= period_eff;
        d_reg      <= ONE - period_eff;
      end
      if (restart) begin
        ecnt_reg <= '0;
      end else if (evt_next && ecnt_reg != ECNT_MAX) begin
        ecnt_reg <= ecnt_reg + 1'b1;
      end
    end
  end

  assign SP   = ctrl_reg.sp;
  assign SD   = ctrl_reg.sd;
  assign CI   = ctrl_reg.ci;
  assign BUSY = ctrl_reg.busy;
  assign D    = d_reg;
  assign EVT  = evt_reg;
  assign ECNT = ecnt_reg;

endmodule

// File: tb/tb_cnt_reload_seq.sv
// Directed bench: two sequencers (AUTO=1 and AUTO=0) each driving a four-stage 4-bit
// counter chain; expected event cycles are queued at stimulus time and checked on EVT.
module tb_cnt_reload_seq;

  logic        CK = 1'b0;
  logic        cd = 1'b1;
  logic        ldv = 1'b0;
  logic [15:0] ldd = '0;
  logic        go = 1'b0;
  logic        halt = 1'b0;
  logic        stop = 1'b0;

  logic [1:0]  ldr_w, sp_w, sd_w, ci_w, tc_w, evt_w, busy_w;
  logic [15:0] d_w    [2];
  logic [7:0]  ecnt_w [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int q_main[$];
  int q_os[$];
  bit os_en = 1'b0;

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  cnt_reload_seq #(.WIDTH(16), .AUTO(1'b1)) dut (
    .CK(CK), .CD(cd), .LDV(ldv), .LDD(ldd), .LDR(ldr_w[0]), .GO(go), .HALT(halt),
    .STOP(stop), .TC(tc_w[0]), .SP(sp_w[0]), .SD(sd_w[0]), .CI(ci_w[0]), .D(d_w[0]),
    .EVT(evt_w[0]), .BUSY(busy_w[0]), .ECNT(ecnt_w[0])
  );

  cnt_reload_seq #(.WIDTH(16), .AUTO(1'b0)) dut_os (
    .CK(CK), .CD(cd), .LDV(ldv), .LDD(ldd), .LDR(ldr_w[1]), .GO(go), .HALT(halt),
    .STOP(stop), .TC(tc_w[1]), .SP(sp_w[1]), .SD(sd_w[1]), .CI(ci_w[1]), .D(d_w[1]),
    .EVT(evt_w[1]), .BUSY(busy_w[1]), .ECNT(ecnt_w[1])
  );

  // Cascaded 4-bit loadable up-counters; carry ripples through stages that are at 0xF.
  for (genvar gu = 0; gu < 2; gu++) begin : g_chain
    logic [3:0] stg [4];
    logic [3:0] cin;
    logic       tc_o;

    always_comb begin
      logic c;
      c = ci_w[gu];
      cin = '0;
      for (int i = 0; i < 4; i++) begin
        cin[i] = c;
        c = c & (stg[i] == 4'hF);
      end
      tc_o = c;
    end

    always @(posedge CK) begin
      for (int i = 0; i < 4; i++) begin
        if (sp_w[gu]) begin
          if (sd_w[gu])    stg[i] <= d_w[gu][4*i +: 4];
          else if (cin[i]) stg[i] <= stg[i] + 4'd1;
        end
      end
    end

    assign tc_w[gu] = tc_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge CK) begin
    if (evt_w[0] === 1'b1) begin
      int exp_c;
      if (q_main.size() != 0) exp_c = q_main.pop_front();
      else                    exp_c = -1;
      chk("evt_main_cycle", cyc, exp_c);
      $display("evt main cyc=%0d ecnt=%0d", cyc, ecnt_w[0]);
    end
  end

  always @(negedge CK) begin
    if (os_en && evt_w[1] === 1'b1) begin
      int exp_c;
      if (q_os.size() != 0) exp_c = q_os.pop_front();
      else                  exp_c = -1;
      chk("evt_os_cycle", cyc, exp_c);
      $display("evt oneshot cyc=%0d ecnt=%0d", cyc, ecnt_w[1]);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CK);
  endtask

  task automatic write_p(input logic [15:0] p);
    chk("ldr_before_write", ldr_w[0], 1'b1);
    ldv = 1'b1;
    ldd = p;
    @(negedge CK);
    ldv = 1'b0;
    $display("write period %0d at cyc=%0d", p, cyc);
  endtask

  // Returns the edge number that entered LOAD; events then fall at t0 + k*Pe.
  task automatic go_start(output int t0);
    go = 1'b1;
    @(negedge CK);
    go = 1'b0;
    t0 = cyc;
    $display("go at cyc=%0d", t0);
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    @(negedge CK);
    stop = 1'b0;
    $display("stop at cyc=%0d", cyc);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q_main.size() != 0 && n < budget) begin
      @(negedge CK);
      #1;
      n++;
    end
    chk("drain_main_queue", q_main.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int e1;
    int e2;

    // Reset state
    repeat (3) @(negedge CK);
    cd = 1'b0;
    chk("rst_sp", sp_w[0], 1'b0);
    chk("rst_sd", sd_w[0], 1'b0);
    chk("rst_ci", ci_w[0], 1'b0);
    chk("rst_evt", evt_w[0], 1'b0);
    chk("rst_ecnt", ecnt_w[0], 8'd0);
    chk("rst_busy", busy_w[0], 1'b0);
    chk("rst_ldr", ldr_w[0], 1'b1);
    chk("rst_d", d_w[0], 16'hFFFF);
    wait_cyc(2);

    // P=5 auto-reload
    write_p(16'd5);
    go_start(t0);
    chk("p5_d", d_w[0], 16'hFFFC);
    chk("p5_busy", busy_w[0], 1'b1);
    chk("p5_ldr_after_xfer", ldr_w[0], 1'b1);
    chk("p5_load_sd", sd_w[0], 1'b1);
    for (int j = 1; j <= 3; j++) q_main.push_back(t0 + 5 * j);
    drain(40);
    chk("p5_ecnt", ecnt_w[0], 8'd3);
    stop_pulse();
    chk("p5_stop_busy", busy_w[0], 1'b0);
    chk("p5_stop_ecnt_hold", ecnt_w[0], 8'd3);

    // P=1 and P=0 clamp to 2
    write_p(16'd1);
    go_start(t0);
    chk("p1_d", d_w[0], 16'hFFFF);
    chk("p1_ecnt_clear", ecnt_w[0], 8'd0);
    for (int j = 1; j <= 3; j++) q_main.push_back(t0 + 2 * j);
    drain(20);
    chk("p1_ecnt", ecnt_w[0], 8'd3);
    stop_pulse();
    write_p(16'd0);
    go_start(t0);
    chk("p0_d", d_w[0], 16'hFFFF);
    for (int j = 1; j <= 3; j++) q_main.push_back(t0 + 2 * j);
    drain(20);
    stop_pulse();

    // One-shot with P=4
    write_p(16'd4);
    os_en = 1'b1;
    go_start(t0);
    chk("os_d", d_w[1], 16'hFFFD);
    q_os.push_back(t0 + 4);
    q_main.push_back(t0 + 4);
    q_main.push_back(t0 + 8);
    drain(30);
    chk("os_queue_empty", q_os.size(), 0);
    chk("os_busy", busy_w[1], 1'b0);
    chk("os_ecnt", ecnt_w[1], 8'd1);
    stop_pulse();
    wait_cyc(4);
    os_en = 1'b0;

    // HALT for 3 cycles mid-RUN with P=6, then TC and HALT together
    write_p(16'd6);
    go_start(t0);
    chk("p6_d", d_w[0], 16'hFFFB);
    e1 = t0 + 6;
    q_main.push_back(e1);
    drain(20);
    wait_cyc(1);
    halt = 1'b1;
    q_main.push_back(e1 + 9);
    @(negedge CK);
    chk("hold_sp", sp_w[0], 1'b0);
    chk("hold_sd", sd_w[0], 1'b0);
    chk("hold_busy", busy_w[0], 1'b1);
    wait_cyc(2);
    halt = 1'b0;
    drain(30);
    e2 = e1 + 9;
    q_main.push_back(e2 + 6);
    wait_cyc(5);
    halt = 1'b1;
    @(negedge CK);
    chk("tc_halt_load_sd", sd_w[0], 1'b1);
    chk("tc_halt_load_sp", sp_w[0], 1'b1);
    halt = 1'b0;
    q_main.push_back(e2 + 12);
    drain(30);
    stop_pulse();

    // Period write P=8 while running with P=5
    write_p(16'd5);
    go_start(t0);
    e1 = t0 + 5;
    e2 = t0 + 10;
    q_main.push_back(e1);
    q_main.push_back(e2);
    wait_cyc(6);
    chk("mid_ldr_ready", ldr_w[0], 1'b1);
    ldv = 1'b1;
    ldd = 16'd8;
    @(negedge CK);
    ldv = 1'b0;
    chk("mid_ldr_low", ldr_w[0], 1'b0);
    q_main.push_back(e2 + 8);
    q_main.push_back(e2 + 16);
    wait_cyc(2);
    chk("mid_ldr_low_before_load", ldr_w[0], 1'b0);
    chk("mid_d_old", d_w[0], 16'hFFFC);
    @(negedge CK);
    chk("mid_ldr_after_load", ldr_w[0], 1'b1);
    chk("mid_d_new", d_w[0], 16'hFFF9);
    drain(40);
    stop_pulse();

    // CD mid-RUN
    write_p(16'd5);
    go_start(t0);
    q_main.push_back(t0 + 5);
    drain(20);
    wait_cyc(2);
    cd = 1'b1;
    @(negedge CK);
    cd = 1'b0;
    chk("cd_busy", busy_w[0], 1'b0);
    chk("cd_ecnt", ecnt_w[0], 8'd0);
    chk("cd_sp", sp_w[0], 1'b0);
    chk("cd_ldr", ldr_w[0], 1'b1);
    chk("cd_d", d_w[0], 16'hFFFF);
    wait_cyc(6);
    chk("cd_needs_go", busy_w[0], 1'b0);

    // STOP on the same edge as TC
    write_p(16'd5);
    go_start(t0);
    q_main.push_back(t0 + 5);
    drain(20);
    wait_cyc(4);
    stop = 1'b1;
    @(negedge CK);
    stop = 1'b0;
    chk("stop_tc_evt", evt_w[0], 1'b0);
    chk("stop_tc_busy", busy_w[0], 1'b0);
    chk("stop_tc_ecnt", ecnt_w[0], 8'd1);
    wait_cyc(3);

    // ECNT saturation over 300 events at P=2
    write_p(16'd2);
    go_start(t0);
    for (int j = 1; j <= 300; j++) q_main.push_back(t0 + 2 * j);
    drain(700);
    chk("ecnt_saturate", ecnt_w[0], 8'd255);
    stop_pulse();
    chk("ecnt_sat_hold", ecnt_w[0], 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
